// File: rtl/match_result_collector.sv
// -----------------------------------------------------------------------------
// match_result_collector
//
// Consumer end of the match-block result handshake. Each result offered by the
// producer (valid held high until acknowledged) is acknowledged exactly once
// with a single-cycle pulse and pushed into a result FIFO. Software drains the
// FIFO and reads status and counters over an Avalon-MM slave.
//
// Optional build macro: RESULT_TIMESTAMP_EN
//   Adds a 16-bit free-running cycle counter. Each FIFO entry records the
//   counter value of its ACK cycle, returned in RESULT readdata[30:15].
//   Requires DATA_W <= 15.
//
// Ports:
//   clock                  system clock
//   reset                  synchronous, active-high reset
//   coe_globalfreeze       global freeze
//   coe_localfreeze        local freeze (frozen only when both are high)
//   match_data_in          result word from the match block
//   match_data_valid       result valid, held until acknowledged
//   match_data_ack         single-cycle acknowledge pulse
//   avs_result_address     register select
//   avs_result_read        read strobe
//   avs_result_write       write strobe
//   avs_result_writedata   write data
//   avs_result_readdata    read data, registered, read latency 1
//
// Register map:
//   0 RESULT   [31] entry valid, [DATA_W-1:0] result (pops when not empty)
//   1 STATUS   [31] full, [30] empty, [15:0] occupancy; write bit0=1 flushes
//   2 ACCEPTED saturating count of acknowledged results
//   3 STALLS   saturating count of full-FIFO stall cycles; write bit0=1 clears
//              ACCEPTED and STALLS
// -----------------------------------------------------------------------------
module match_result_collector #(
  parameter int FIFO_DEPTH = 16,
  parameter int DATA_W     = 10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              coe_globalfreeze,
  input  logic              coe_localfreeze,
  input  logic [DATA_W-1:0] match_data_in,
  input  logic              match_data_valid,
  output logic              match_data_ack,
  input  logic [1:0]        avs_result_address,
  input  logic              avs_result_read,
  input  logic              avs_result_write,
  input  logic [31:0]       avs_result_writedata,
  output logic [31:0]       avs_result_readdata
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
`ifdef RESULT_TIMESTAMP_EN
  localparam int ENTRY_W = DATA_W + 16;
`else
  localparam int ENTRY_W = DATA_W;
`endif

  localparam logic [1:0] ADDR_RESULT   = 2'd0;
  localparam logic [1:0] ADDR_STATUS   = 2'd1;
  localparam logic [1:0] ADDR_ACCEPTED = 2'd2;
  localparam logic [1:0] ADDR_STALLS   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACK  = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t state, state_next;

  logic               frozen;
  logic               stall;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;
  logic               flush;
  logic               clear_counts;
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [CW-1:0]      count;
  logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
  logic [ENTRY_W-1:0] entry_in;
  logic [ENTRY_W-1:0] head;
  logic [31:0]        accepted_count;
  logic [31:0]        stall_count;
  logic [31:0]        result_word;
  logic [31:0]        status_word;

  // Only bit 0 of the write data carries a command.
  logic unused_writedata;
  assign unused_writedata = ^avs_result_writedata[31:1];

  assign frozen       = coe_globalfreeze & coe_localfreeze;
  assign fifo_full    = (count == CW'(FIFO_DEPTH));
  assign fifo_empty   = (count == '0);
  assign flush        = avs_result_write && (avs_result_address == ADDR_STATUS)
                        && avs_result_writedata[0];
  assign clear_counts = avs_result_write && (avs_result_address == ADDR_STALLS)
                        && avs_result_writedata[0];
  assign pop          = avs_result_read && (avs_result_address == ADDR_RESULT)
                        && !fifo_empty;
  // A flush in the ACK cycle discards that cycle's capture.
  assign push         = (state == S_ACK) && !flush;

  // ---------------------------------------------------------------------------
  // Handshake FSM
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_next     = state;
    match_data_ack = 1'b0;
    stall          = 1'b0;
    unique case (state)
      S_IDLE: begin
        // Freeze blocks new captures and is not counted as a stall.
        if (match_data_valid && !frozen) begin
          if (!fifo_full) state_next = S_ACK;
          else            stall      = 1'b1;
        end
      end
      S_ACK: begin
        match_data_ack = 1'b1;
        state_next     = S_DROP;
      end
      S_DROP: begin
        // Wait for the producer to release valid so one result is never
        // captured twice.
        if (!match_data_valid) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Optional capture timestamp
  // ---------------------------------------------------------------------------
`ifdef RESULT_TIMESTAMP_EN
  logic [15:0] cycle_count;

  always_ff @(posedge clock) begin
    if (reset) cycle_count <= '0;
    else       cycle_count <= cycle_count + 16'd1;
  end

  assign entry_in = {cycle_count, match_data_in};
`else
  assign entry_in = match_data_in;
`endif

  // ---------------------------------------------------------------------------
  // Result FIFO
  // ---------------------------------------------------------------------------
  // NOTE: the storage array is not reset; occupancy and pointers define which
  // entries are meaningful, so resetting the data would only cost logic.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= entry_in;
  end

  // The ACK entry check guarantees space, so a push never meets a full FIFO.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

  // ---------------------------------------------------------------------------
  // Saturating counters; an explicit clear wins over a coincident increment.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset || clear_counts) begin
      accepted_count <= '0;
      stall_count    <= '0;
    end else begin
      if ((state == S_ACK) && (accepted_count != '1))
        accepted_count <= accepted_count + 32'd1;
      if (stall && (stall_count != '1))
        stall_count <= stall_count + 32'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Register read
  // ---------------------------------------------------------------------------
  always_comb begin
    result_word = '0;
    if (!fifo_empty) begin
      result_word[31]          = 1'b1;
      result_word[DATA_W-1:0]  = head[DATA_W-1:0];
`ifdef RESULT_TIMESTAMP_EN
      result_word[30:15]       = head[DATA_W +: 16];
`endif
    end
  end

  always_comb begin
    status_word       = '0;
    status_word[31]   = fifo_full;
    status_word[30]   = fifo_empty;
    status_word[15:0] = 16'(count);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      avs_result_readdata <= '0;
    end else if (avs_result_read) begin
      case (avs_result_address)
        ADDR_RESULT:   avs_result_readdata <= result_word;
        ADDR_STATUS:   avs_result_readdata <= status_word;
        ADDR_ACCEPTED: avs_result_readdata <= accepted_count;
        ADDR_STALLS:   avs_result_readdata <= stall_count;
        default:       avs_result_readdata <= '0;
      endcase
    end
  end

endmodule
